// File: rtl/ahb_resp_mux_pipe.sv
// AHB response multiplexer: registers the data-phase slave select, forwards the selected
// slave response, and provides a default slave plus error counting.
module ahb_resp_mux_pipe #(
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned PAY_LOAD    = 34,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [CHANNEL_NUM-1:0]          sel_addr,
  input  logic                            trans_valid,
  input  logic [CHANNEL_NUM*PAY_LOAD-1:0] payload_in,
  input  logic                            clr,
  output logic [PAY_LOAD-1:0]             payload_out,
  output logic [CHANNEL_NUM-1:0]          dsel,
  output logic [CNT_W-1:0]                err_cnt,
  output logic                            sel_err
);

  typedef enum logic [1:0] {
    S_OKAY = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } state_e;

  state_e              state;
  state_e              state_nxt;
  logic                hready_out;
  logic                sel_nonzero;
  logic                sel_onehot;
  logic                sel_multi;
  logic [PAY_LOAD-1:0] slave_pay;
  logic [PAY_LOAD-1:0] dflt_pay;

  // Address-phase select classification
  assign sel_nonzero = |sel_addr;
  assign sel_onehot  = sel_nonzero && ((sel_addr & (sel_addr - CHANNEL_NUM'(1))) == '0);
  assign sel_multi   = sel_nonzero && !sel_onehot;

  // Default-slave state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_OKAY;
    else          state <= state_nxt;
  end

  // Default-slave next state; ERR1 always advances so the error response is two cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_ERR1:  state_nxt = S_ERR2;
      default: begin
        if (hready_out) state_nxt = (trans_valid && !sel_onehot) ? S_ERR1 : S_OKAY;
      end
    endcase
  end

  // Default-slave response {data, HRESP, HREADY}
  always_comb begin
    dflt_pay = '0;
    case (state)
      S_ERR1:  dflt_pay[1:0] = 2'b10;
      S_ERR2:  dflt_pay[1:0] = 2'b11;
      default: dflt_pay[1:0] = 2'b01;
    endcase
  end

  // AND-OR mux; dsel is one-hot or zero by construction
  always_comb begin
    slave_pay = '0;
    for (int i = 0; i < int'(CHANNEL_NUM); i++) begin
      if (dsel[i]) slave_pay = slave_pay | payload_in[i*PAY_LOAD +: PAY_LOAD];
    end
  end

  assign payload_out = (|dsel) ? slave_pay : dflt_pay;
  assign hready_out  = payload_out[0];

  // Data-phase select only advances when the bus is ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        dsel <= '0;
    else if (hready_out) dsel <= sel_onehot ? sel_addr : '0;
  end

  // Saturating count of error-response final cycles; clear has priority
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (payload_out[1] && payload_out[0] && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // Sticky multi-hot select flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                     sel_err <= 1'b0;
    else if (clr)                     sel_err <= 1'b0;
    else if (hready_out && sel_multi) sel_err <= 1'b1;
  end

endmodule

// File: tb/tb_ahb_resp_mux_pipe.sv
// Scoreboard bench for ahb_resp_mux_pipe (4 channels, 34-bit payload, 2-bit error counter).
module tb_ahb_resp_mux_pipe;

  localparam int unsigned CH = 4;
  localparam int unsigned PL = 34;
  localparam int unsigned CW = 2;
  localparam int unsigned OW = PL + CH + CW + 1;

  logic              HCLK;
  logic              HRESETn;
  logic [CH-1:0]     sel_addr;
  logic              trans_valid;
  logic [CH*PL-1:0]  payload_in;
  logic              clr;
  logic [PL-1:0]     payload_out;
  logic [CH-1:0]     dsel;
  logic [CW-1:0]     err_cnt;
  logic              sel_err;

  logic [OW-1:0] obs;
  logic [OW-1:0] exp_q[$];
  string         nm_q[$];
  logic [OW-1:0] ev;
  string         nm;
  int            vectors;
  int            miscompares;

  ahb_resp_mux_pipe #(.CHANNEL_NUM(CH), .PAY_LOAD(PL), .CNT_W(CW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .sel_addr    (sel_addr),
    .trans_valid (trans_valid),
    .payload_in  (payload_in),
    .clr         (clr),
    .payload_out (payload_out),
    .dsel        (dsel),
    .err_cnt     (err_cnt),
    .sel_err     (sel_err)
  );

  assign obs = {payload_out, dsel, err_cnt, sel_err};

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [PL-1:0] pl(input logic [31:0] d, input logic r, input logic h);
    return {d, r, h};
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_pay(input int i, input logic [PL-1:0] v);
    payload_in[i*PL +: PL] = v;
  endtask

  task automatic idle_slaves();
    for (int i = 0; i < int'(CH); i++) set_pay(i, pl(32'h1000_0000 + 32'(i), 1'b0, 1'b1));
  endtask

  task automatic push(input string n, input logic [PL-1:0] p, input logic [CH-1:0] d,
                      input logic [CW-1:0] c, input logic s);
    exp_q.push_back({p, d, c, s});
    nm_q.push_back(n);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; clr = 1'b0; idle_slaves();
    sel_addr = 4'b0100; trans_valid = 1'b1;
    set_pay(2, pl(32'hA5A5_A5A5, 1'b0, 1'b1));
    push("reset_state", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick(); tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    #2 HRESETn = 1'b1;
    push("first_sample_fwd", pl(32'hA5A5_A5A5, 0, 1), 4'b0100, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    idle_slaves();
  endtask

  task automatic test_forward();
    sel_addr = 4'b0001; trans_valid = 1'b1;
    push("fwd_ch0", pl(32'h1000_0000, 0, 1), 4'b0001, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    set_pay(0, pl(32'hCAFE_0000, 0, 1));
    push("fwd_zero_latency", pl(32'hCAFE_0000, 0, 1), 4'b0001, 2'd0, 1'b0);
    #1;
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    idle_slaves();
    sel_addr = 4'b1000; trans_valid = 1'b0;
    push("fwd_idle_onehot", pl(32'h1000_0003, 0, 1), 4'b1000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
  endtask

  task automatic test_wait_states();
    sel_addr = 4'b0010; trans_valid = 1'b1;
    push("ws_select", pl(32'h1000_0001, 0, 1), 4'b0010, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    set_pay(1, pl(32'h0000_BEEF, 0, 0));
    sel_addr = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("ws_hold%0d", k), pl(32'h0000_BEEF, 0, 0), 4'b0010, 2'd0, 1'b0);
      tick();
      ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
      if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    end
    set_pay(1, pl(32'h0000_BEEF, 0, 1));
    push("ws_ready_back", pl(32'h0000_BEEF, 0, 1), 4'b0010, 2'd0, 1'b0);
    #1;
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    push("ws_load_next", pl(32'h1000_0000, 0, 1), 4'b0001, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    idle_slaves();
  endtask

  task automatic test_slave_err();
    sel_addr = 4'b0100; trans_valid = 1'b1;
    push("serr_select", pl(32'h1000_0002, 0, 1), 4'b0100, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    sel_addr = 4'b0000; trans_valid = 1'b0;
    set_pay(2, pl(32'h0000_DEAD, 1, 0));
    push("serr_first", pl(32'h0000_DEAD, 1, 0), 4'b0100, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    set_pay(2, pl(32'h0000_DEAD, 1, 1));
    push("serr_final", pl(32'h0000_DEAD, 1, 1), 4'b0100, 2'd0, 1'b0);
    #1;
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    push("serr_counted", pl(0, 0, 1), 4'b0000, 2'd1, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    idle_slaves();
  endtask

  task automatic test_unmapped();
    clr = 1'b1;
    push("unm_clr", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b0; sel_addr = 4'b0000; trans_valid = 1'b1;
    push("unm_err1", pl(0, 1, 0), 4'b0000, 2'd0, 1'b0);
    push("unm_err2", pl(0, 1, 1), 4'b0000, 2'd0, 1'b0);
    push("unm_done", pl(0, 0, 1), 4'b0000, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      trans_valid = 1'b0;
      ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
      if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    end
  endtask

  task automatic test_multi_hot();
    sel_addr = 4'b0011; trans_valid = 1'b0;
    push("mh_idle_okay", pl(0, 0, 1), 4'b0000, 2'd1, 1'b1);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    sel_addr = 4'b0000; clr = 1'b1;
    push("mh_clr", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b0; sel_addr = 4'b0110; trans_valid = 1'b1;
    push("mh_valid_err1", pl(0, 1, 0), 4'b0000, 2'd0, 1'b1);
    push("mh_valid_err2", pl(0, 1, 1), 4'b0000, 2'd0, 1'b1);
    push("mh_valid_done", pl(0, 0, 1), 4'b0000, 2'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      sel_addr = 4'b0000; trans_valid = 1'b0;
      ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
      if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    end
    clr = 1'b1;
    push("mh_clr2", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel_addr = 4'b0000; trans_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push($sformatf("b2b_err1_%0d", k), pl(0, 1, 0), 4'b0000, 2'(k > 3 ? 3 : k), 1'b0);
      push($sformatf("b2b_err2_%0d", k), pl(0, 1, 1), 4'b0000, 2'(k > 3 ? 3 : k), 1'b0);
      for (int j = 0; j < 2; j++) begin
        tick();
        ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
        if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
      end
    end
    trans_valid = 1'b0;
    push("b2b_saturated", pl(0, 0, 1), 4'b0000, 2'd3, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b1;
    push("b2b_clr", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b0; trans_valid = 1'b1;
    push("prio_err1", pl(0, 1, 0), 4'b0000, 2'd0, 1'b0);
    push("prio_err2", pl(0, 1, 1), 4'b0000, 2'd0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      tick();
      ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
      if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    end
    clr = 1'b1; trans_valid = 1'b0; sel_addr = 4'b0011;
    push("prio_clr_wins", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    clr = 1'b0; sel_addr = 4'b0000;
  endtask

  task automatic test_reset_mid_error();
    sel_addr = 4'b0000; trans_valid = 1'b1;
    push("rst_in_err1", pl(0, 1, 0), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    trans_valid = 1'b0;
    HRESETn = 1'b0;
    push("rst_async_err", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    #2;
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    tick();
    HRESETn = 1'b1;
    push("rst_restart_okay", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    sel_addr = 4'b0100; trans_valid = 1'b1;
    push("rst_pre_fwd", pl(32'h1000_0002, 0, 1), 4'b0100, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    HRESETn = 1'b0;
    push("rst_async_dsel", pl(0, 0, 1), 4'b0000, 2'd0, 1'b0);
    #2;
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
    tick();
    HRESETn = 1'b1; sel_addr = 4'b0001;
    push("rst_first_sample", pl(32'h1000_0000, 0, 1), 4'b0001, 2'd0, 1'b0);
    tick();
    ev = exp_q.pop_front(); nm = nm_q.pop_front(); vectors++;
    if (obs !== ev) begin miscompares++; $display("FAIL %s: got %h expected %h", nm, obs, ev); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    HRESETn = 1'b0; sel_addr = '0; trans_valid = 1'b0; clr = 1'b0; payload_in = '0;
    test_reset();
    test_forward();
    test_wait_states();
    test_slave_err();
    test_unmapped();
    test_multi_hot();
    test_back_to_back();
    test_reset_mid_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux_pipe.md
AHB_RESP_MUX_PIPE -- requirements
Module: ahb_resp_mux_pipe

Interface
REQ-001 Parameter CHANNEL_NUM, default 4: number of slave response channels; the legal range is 2..16.
REQ-002 Parameter PAY_LOAD, default 34: width of each response payload; layout is [PAY_LOAD-1:2] HRDATA, [1] HRESP, [0] HREADYOUT.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 HCLK  input  1  single clock for the block; the block SHALL use one clock, and all state SHALL update on its rising edge.
REQ-005 HRESETn  input  1  reset; the block SHALL treat it as asynchronous and active-low.
REQ-006 sel_addr  input  CHANNEL_NUM  address-phase slave select; one-hot when legal.
REQ-007 trans_valid  input  1  address-phase transfer active (HTRANS is NONSEQ or SEQ).
REQ-008 payload_in  input  CHANNEL_NUM x PAY_LOAD  per-slave response payloads.
REQ-009 clr  input  1  synchronous clear for the error counter and the sticky flag.
REQ-010 payload_out  output  PAY_LOAD  muxed data-phase response; bit 0 is the system HREADY.
REQ-011 dsel  output  CHANNEL_NUM  registered data-phase select.
REQ-012 err_cnt  output  CNT_W  saturating count of completed error responses.
REQ-013 sel_err  output  1  sticky flag; set when sel_addr is multi-hot.

Function
REQ-014 hready_out SHALL equal payload_out[0].
REQ-015 On a rising edge with hready_out=1, dsel SHALL load sel_addr if sel_addr is one-hot; otherwise dsel SHALL load 0.
REQ-016 On a rising edge with hready_out=0, dsel SHALL hold its value.
REQ-017 If dsel is nonzero, payload_out SHALL equal payload_in[index of dsel], combinationally and with zero added latency.
REQ-018 The default-slave FSM SHALL have three states: OKAY, ERR1 and ERR2.
REQ-019 If dsel=0, payload_out SHALL be driven from the FSM state: OKAY = {data 0, HRESP 0, HREADY 1}; ERR1 = {0, 1, 0}; ERR2 = {0, 1, 1}.
REQ-020 Transition rule for OKAY and ERR2: on an edge with hready_out=1, if trans_valid=1 and sel_addr is not one-hot (zero or multi-hot), the FSM SHALL go to ERR1; otherwise it SHALL go to OKAY.
REQ-021 ERR1 SHALL go to ERR2 unconditionally on the next edge, so every default error response is exactly two cycles.
REQ-022 While the FSM is in ERR1 or ERR2, dsel SHALL be 0.
REQ-023 If trans_valid=0 and sel_addr=0, the response SHALL be a zero-wait OKAY from the default slave.
REQ-024 If trans_valid=0 and sel_addr is one-hot, the selected slave SHALL be forwarded.
REQ-025 sel_err SHALL set on any edge where hready_out=1 and sel_addr has more than one bit set, regardless of trans_valid.
REQ-026 sel_err SHALL remain set until clr or reset.
REQ-027 err_cnt SHALL increment by 1 on each edge where payload_out[1]=1 and payload_out[0]=1, which is the final cycle of an error response from either a slave or the default slave.
REQ-028 err_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 If clr and an increment or sel_err set occur on the same edge, clr SHALL win: err_cnt=0 and sel_err=0.
REQ-030 A slave that holds HREADYOUT=0 SHALL stall the system; dsel SHALL hold for any number of wait states.

Reset
REQ-031 While HRESETn=0, the block SHALL drive: dsel=0, FSM=OKAY, err_cnt=0, sel_err=0, payload_out={0,0,1}.
REQ-032 Reset asserted mid-error (in ERR1 or ERR2) SHALL abort the error response immediately; after reset the block SHALL restart in OKAY.
REQ-033 After HRESETn deasserts, the first edge SHALL perform a normal address-phase sample.

Verification
REQ-034 Forwarding: CHANNEL_NUM=4, sel_addr=4'b0100, trans_valid=1, then payload_in[2]={data 0xA5A5A5A5, HRESP 0, HREADY 1} -> dsel=4'b0100 and payload_out=0xA5A5A5A5_0_1 in the following cycle.
REQ-035 Wait states: slave 1 drives HREADY 0 for 3 cycles while a new sel_addr=4'b0001 is presented -> dsel stays 4'b0010 for those 3 cycles and loads 4'b0001 on the edge after HREADY returns to 1.
REQ-036 Unmapped address: trans_valid=1, sel_addr=0 -> payload_out sequence {0,1,0} then {0,1,1}; err_cnt increments 0->1.
REQ-037 Multi-hot select: sel_addr=4'b0011, trans_valid=0 -> OKAY zero-wait response and sel_err=1; then clr=1 -> sel_err=0.
REQ-038 Saturation and clear priority: CNT_W=2 with 5 back-to-back default errors -> err_cnt=3; clr together with an error final cycle -> err_cnt=0.
REQ-039 Reset in ERR1: HRESETn pulled low -> payload_out={0,0,1} and dsel=0 immediately, without waiting for a clock edge.
